intersection_scheduler: RTL

Four-phase green-time scheduler for a signalised intersection. It extends the two-road highway/country light controller to four approach phases. Approach requests (car sensors) are arbitrated round-robin, and each phase is sequenced through green, yellow and all-red with minimum and maximum green timers. An emergency preempt input forces a chosen phase to green.

---
 rtl/intersection_scheduler_if.sv | 20 ++
 rtl/intersection_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the four-phase intersection scheduler and its environment.
// The controller side is the slave; the sensor/lamp-driver side is the master.
interface intersection_scheduler_if;
    logic [3:0] req;
    logic       preempt;
    logic [1:0] preempt_ph;
    logic [7:0] light;
    logic [3:0] grant;
    logic [1:0] state;

    modport master (
        output req, preempt, preempt_ph,
        input  light, grant, state
    );

    modport slave (
        input  req, preempt, preempt_ph,
        output light, grant, state
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Four-phase signalised-intersection scheduler: round-robin green arbitration with
// min/max green, fixed yellow and all-red clearance, and emergency preempt.
module intersection_scheduler #(
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 16,
    parameter int unsigned YEL_CYC    = 3,
    parameter int unsigned ALLRED_CYC = 2
) (
    input  logic                    clk,
    input  logic                    clear,
    intersection_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALLRED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    // Timer values seen in the last cycle of each interval (green length = timer + 1).
    localparam logic [7:0] L_MIN_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0] L_MAX_LAST = 8'(MAX_GREEN - 1);
    localparam logic [7:0] L_YEL_LAST = 8'(YEL_CYC - 1);
    localparam logic [7:0] L_AR_LAST  = 8'(ALLRED_CYC - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [1:0] r_cur;
    logic [1:0] w_cur_next;
    logic [1:0] r_nxt;
    logic [1:0] w_nxt_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;

    logic [3:0] w_cur_onehot;
    logic       w_other_req;
    logic [1:0] w_rr_next;
    logic       w_green_end;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_GREEN;
            r_cur   <= 2'd0;
            r_nxt   <= 2'd0;
            r_timer <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
            r_nxt   <= w_nxt_next;
            r_timer <= w_timer_next;
        end
    end

    assign w_cur_onehot = 4'b0001 << r_cur;
    assign w_other_req  = |(bus.req & ~w_cur_onehot);

    // Descending scan so the nearest requesting phase after cur wins.
    always_comb begin
        w_rr_next = r_cur;
        for (int k = 3; k >= 1; k--) begin
            if (bus.req[r_cur + 2'(k)]) begin
                w_rr_next = r_cur + 2'(k);
            end
        end
    end

    assign w_green_end = w_other_req && (r_timer >= L_MIN_LAST) &&
                         (!bus.req[r_cur] || (r_timer >= L_MAX_LAST));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_nxt_next   = r_nxt;
        case (r_state)
            ST_GREEN: begin
                if (bus.preempt) begin
                    if (bus.preempt_ph != r_cur) begin
                        w_state_next = ST_YELLOW;
                        w_nxt_next   = bus.preempt_ph;
                    end
                end else if (w_green_end) begin
                    w_state_next = ST_YELLOW;
                    w_nxt_next   = w_rr_next;
                end
            end
            ST_YELLOW: begin
                if (bus.preempt) begin
                    w_nxt_next = bus.preempt_ph;
                end
                if (r_timer == L_YEL_LAST) begin
                    w_state_next = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (bus.preempt) begin
                    w_nxt_next = bus.preempt_ph;
                end
                if (r_timer == L_AR_LAST) begin
                    w_state_next = ST_GREEN;
                    w_cur_next   = w_nxt_next;
                end
            end
            default: begin
                w_state_next = ST_ALLRED;
                w_nxt_next   = 2'd0;
            end
        endcase

        if (w_state_next != r_state) begin
            w_timer_next = 8'd0;
        end else if (r_timer == 8'hFF) begin
            w_timer_next = r_timer;
        end else begin
            w_timer_next = r_timer + 8'd1;
        end
    end

    // Lamps and grant decode only from registered state.
    always_comb begin
        bus.light = 8'h00;
        bus.grant = 4'b0000;
        case (r_state)
            ST_GREEN: begin
                bus.light[{r_cur, 1'b0} +: 2] = 2'd2;
                bus.grant                     = w_cur_onehot;
            end
            ST_YELLOW: begin
                bus.light[{r_cur, 1'b0} +: 2] = 2'd1;
            end
            default: begin
            end
        endcase
    end

    assign bus.state = r_state;

endmodule
